// File: rtl/mandel_pkg.sv
// mandel_pkg: shared fixed-point types, viewport constants and the pixel clamp helper.
package mandel_pkg;
  localparam int WORD_LENGTH = 16;
  localparam int FRAC = 8;
  localparam int COORD_W = 11;
  localparam int SCALE_SHIFT = 9;
  localparam int NUM_W = WORD_LENGTH + SCALE_SHIFT;
  typedef logic signed [WORD_LENGTH-1:0] fixed_t;
  localparam fixed_t ONE = fixed_t'(1) <<< FRAC;
  // Returns {in_range, coord}; skip marks a negative offset or a degenerate viewport.
  function automatic logic [COORD_W:0] clamp_coord(input logic [NUM_W-1:0] q, input logic skip,
                                                   input logic [COORD_W-1:0] dim);
    return skip ? '0 : (q >= NUM_W'(dim)) ? {1'b0, dim - COORD_W'(1)} : {1'b1, q[COORD_W-1:0]};
  endfunction
endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle; start also performs the first step.
module serial_divider #(
  parameter int NUM_W = 25,
  parameter int DEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [NUM_W-1:0] quo_o
);
  localparam int CW = $clog2(NUM_W + 1);
  logic [DEN_W-1:0] rem_q, rem_d, rem_s, den_q, den_s;
  logic [NUM_W-1:0] quo_q, quo_d, num_s;
  logic [DEN_W:0] sh, diff;
  logic [CW-1:0] cnt_q;
  logic done_q, ge;
  always_comb begin
    rem_s = start_i ? '0 : rem_q;
    num_s = start_i ? num_i : quo_q;
    den_s = start_i ? den_i : den_q;
    sh = {rem_s, num_s[NUM_W-1]};
    diff = sh - {1'b0, den_s};
    ge = sh >= {1'b0, den_s};
    rem_d = ge ? diff[DEN_W-1:0] : sh[DEN_W-1:0];
    quo_d = {num_s[NUM_W-2:0], ge};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      den_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= !start_i && cnt_q == CW'(1);
      if (start_i || busy_o) begin
        rem_q <= rem_d;
        den_q <= den_s;
        quo_q <= quo_d;
        cnt_q <= start_i ? CW'(NUM_W - 1) : cnt_q - CW'(1);
      end
    end
  end
  assign busy_o = cnt_q != '0;
  assign done_o = done_q;
  assign quo_o = quo_q;
endmodule

// File: rtl/complex_to_pixel.sv
// complex_to_pixel: maps a fixed-point complex point to the covering screen pixel under center/zoom.
// C2P_DUAL_DIV_EN: divide x and y concurrently on two dividers instead of sequentially on one.
module complex_to_pixel
  import mandel_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        zoom,
  input  fixed_t             real_center,
  input  fixed_t             imag_center,
  input  logic [COORD_W-1:0] screen_width,
  input  logic [COORD_W-1:0] screen_height,
  input  logic               in_valid,
  output logic               in_ready,
  input  fixed_t             re_in,
  input  fixed_t             im_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               in_bounds
);
`ifdef C2P_DUAL_DIV_EN
  typedef enum logic [2:0] {IDLE, SETUP, DIV_X, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SETUP, DIV_X, DIV_Y, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [31:0] zoom_q;
  fixed_t rc_q, ic_q, re_q, im_q, wid, half, rmin, imax;
  logic [COORD_W-1:0] sw_q, sh_q;
  logic [WORD_LENGTH:0] dx, dy;
  logic [WORD_LENGTH-1:0] den;
  logic [NUM_W-1:0] num_x, num_y, qx, qy;
  logic [COORD_W:0] cx, cy;
  logic wz, busy_x, done_x;
  // Zoom beyond ONE shrinks the viewport width to zero; only the low FRAC+1 bits can divide ONE.
  always_comb begin
    wid = (|zoom_q[31:FRAC+1]) ? '0 :
          fixed_t'(WORD_LENGTH'(ONE[FRAC:0] / (zoom_q == 0 ? (FRAC+1)'(1) : zoom_q[FRAC:0])));
    half = wid >>> 1;
    rmin = rc_q - half;
    imax = ic_q + half;
    wz = wid == '0;
    dx = {re_q[WORD_LENGTH-1], re_q} - {rmin[WORD_LENGTH-1], rmin};
    dy = {imax[WORD_LENGTH-1], imax} - {im_q[WORD_LENGTH-1], im_q};
    num_x = (dx[WORD_LENGTH] | wz) ? '0 : {dx[WORD_LENGTH-1:0], SCALE_SHIFT'(0)};
    num_y = (dy[WORD_LENGTH] | wz) ? '0 : {dy[WORD_LENGTH-1:0], SCALE_SHIFT'(0)};
    den = wz ? WORD_LENGTH'(1) : wid;
  end
`ifdef C2P_DUAL_DIV_EN
  logic busy_y, done_y, start;
  assign start = state_q == DIV_X && !busy_x && !busy_y && !done_x;
  serial_divider #(.NUM_W(NUM_W), .DEN_W(WORD_LENGTH)) u_div_x (
    .clk, .reset, .start_i(start), .num_i(num_x), .den_i(den),
    .busy_o(busy_x), .done_o(done_x), .quo_o(qx));
  serial_divider #(.NUM_W(NUM_W), .DEN_W(WORD_LENGTH)) u_div_y (
    .clk, .reset, .start_i(start), .num_i(num_y), .den_i(den),
    .busy_o(busy_y), .done_o(done_y), .quo_o(qy));
`else
  logic [NUM_W-1:0] qx_q;
  // The cycle x completes is also the cycle y is launched on the same divider.
  serial_divider #(.NUM_W(NUM_W), .DEN_W(WORD_LENGTH)) u_div (
    .clk, .reset, .start_i(state_q == DIV_X && !busy_x), .num_i(done_x ? num_y : num_x), .den_i(den),
    .busy_o(busy_x), .done_o(done_x), .quo_o(qy));
  always_ff @(posedge clk) begin
    if (reset) qx_q <= '0;
    else if (state_q == DIV_X && done_x) qx_q <= qy;
  end
  assign qx = qx_q;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid) state_d = SETUP;
      SETUP: state_d = DIV_X;
`ifdef C2P_DUAL_DIV_EN
      DIV_X: if (done_x && done_y) state_d = DONE;
`else
      DIV_X: if (done_x) state_d = DIV_Y;
      DIV_Y: if (done_x) state_d = DONE;
`endif
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      zoom_q <= '0;
      rc_q <= '0;
      ic_q <= '0;
      re_q <= '0;
      im_q <= '0;
      sw_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_valid && in_ready) begin
        zoom_q <= zoom;
        rc_q <= real_center;
        ic_q <= imag_center;
        re_q <= re_in;
        im_q <= im_in;
        sw_q <= screen_width;
        sh_q <= screen_height;
      end
    end
  end
  assign cx = clamp_coord(qx, dx[WORD_LENGTH] | wz, sw_q);
  assign cy = clamp_coord(qy, dy[WORD_LENGTH] | wz, sh_q);
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign x_out = out_valid ? cx[COORD_W-1:0] : '0;
  assign y_out = out_valid ? cy[COORD_W-1:0] : '0;
  assign in_bounds = out_valid & cx[COORD_W] & cy[COORD_W];
endmodule

// File: tb/tb_complex_to_pixel.sv
// tb_complex_to_pixel: directed vectors with hand-computed pixels, latency, hold and reset behaviour.
module tb_complex_to_pixel;
  import mandel_pkg::*;
`ifdef C2P_DUAL_DIV_EN
  localparam int LAT = 27;
`else
  localparam int LAT = 52;
`endif
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_valid, out_ready, in_bounds;
  logic [31:0] zoom;
  fixed_t real_center, imag_center, re_in, im_in;
  logic [COORD_W-1:0] screen_width, screen_height, x_out, y_out;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  complex_to_pixel dut (
    .clk(clk), .reset(reset), .zoom(zoom), .real_center(real_center), .imag_center(imag_center),
    .screen_width(screen_width), .screen_height(screen_height), .in_valid(in_valid), .in_ready(in_ready),
    .re_in(re_in), .im_in(im_in), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .y_out(y_out), .in_bounds(in_bounds));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic send(input int z, input int rc, input int ic, input int sw, input int sh,
                      input int re, input int im);
    @(negedge clk);
    zoom = z;
    real_center = fixed_t'(rc);
    imag_center = fixed_t'(ic);
    screen_width = COORD_W'(sw);
    screen_height = COORD_W'(sh);
    re_in = fixed_t'(re);
    im_in = fixed_t'(im);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic run(input string tag, input int z, input int rc, input int ic, input int sw, input int sh,
                     input int re, input int im, input int ex, input int ey, input int eb,
                     input bit early, input int hold);
    int n = 0;
    out_ready = early;
    send(z, rc, ic, sw, sh, re, im);
    while (!out_valid && n < 200) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " x"}, 32'(x_out), ex);
    check({tag, " y"}, 32'(y_out), ey);
    check({tag, " in_bounds"}, 32'(in_bounds), eb);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold valid"}, 32'(out_valid), 1);
      check({tag, " hold x"}, 32'(x_out), ex);
      check({tag, " hold in_ready"}, 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, " idle in_ready"}, 32'(in_ready), 1);
    check({tag, " idle out_valid"}, 32'(out_valid), 0);
    out_ready = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    zoom = 0;
    real_center = '0;
    imag_center = '0;
    screen_width = '0;
    screen_height = '0;
    re_in = '0;
    im_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready), 1);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset x", 32'(x_out), 0);
    check("reset y", 32'(y_out), 0);
    check("reset in_bounds", 32'(in_bounds), 0);
    reset = 1'b0;
    run("origin", 1, 0, 0, 512, 512, 0, 0, 256, 256, 1, 1'b0, 0);
    run("corner", 1, 0, 0, 512, 512, -128, 127, 0, 2, 1, 1'b0, 0);
    run("right", 1, 0, 0, 512, 512, 127, 0, 510, 256, 1, 1'b0, 0);
    run("left_out", 1, 0, 0, 512, 512, -129, 0, 0, 256, 0, 1'b0, 0);
    run("right_out", 1, 0, 0, 512, 512, 128, 0, 511, 256, 0, 1'b0, 0);
    run("top_out", 1, 0, 0, 512, 512, 0, 129, 256, 0, 0, 1'b0, 0);
    run("bot_out", 1, 0, 0, 512, 512, 0, -129, 256, 511, 0, 1'b0, 0);
    run("zoom2", 2, 0, 0, 512, 512, 0, 0, 256, 256, 1, 1'b1, 0);
    run("zoom512", 512, 0, 0, 512, 512, 0, 0, 0, 0, 0, 1'b0, 0);
    run("zoom0", 0, 0, 0, 512, 512, 0, 0, 256, 256, 1, 1'b0, 0);
    run("centered", 1, 256, -256, 512, 512, 300, -300, 344, 344, 1, 1'b0, 0);
    run("small_screen", 1, 0, 0, 300, 200, 0, 0, 256, 199, 0, 1'b0, 0);
    run("hold", 1, 0, 0, 512, 512, -78, 78, 100, 100, 1, 1'b0, 10);
    send(1, 0, 0, 512, 512, 0, 0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("midreset in_ready", 32'(in_ready), 1);
    check("midreset out_valid", 32'(out_valid), 0);
    check("midreset x", 32'(x_out), 0);
    reset = 1'b0;
    run("after_reset", 1, 0, 0, 512, 512, 127, -129, 510, 511, 0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
